// File: rtl/jk_drive_pkg.sv
// jk_drive_pkg: shared FSM state type and 2-bit {J,K} excitation codes for jk_drive_seq.
package jk_drive_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] TOGGLE = 2'b11;
endpackage

// File: rtl/jk_excite.sv
// jk_excite: combinational per-bit J/K excitation mapping a target and current Q to {J,K}.
//   tgt  in  WIDTH  target Q
//   cur  in  WIDTH  current Q of the bank (only used by the toggle build)
//   j,k  out WIDTH  excitation
// Build option JK_TOGGLE_EN: toggle excitation instead of set/reset excitation.
module jk_excite
    import jk_drive_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);
`ifndef JK_TOGGLE_EN
    logic unused_cur;
    assign unused_cur = ^cur;
`endif
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
`ifdef JK_TOGGLE_EN
        assign {j[g], k[g]} = (tgt[g] ^ cur[g]) ? TOGGLE : HOLD;
`else
        assign {j[g], k[g]} = tgt[g] ? SET : RESET;
`endif
    end
endmodule

// File: rtl/jk_drive_seq.sv
// jk_drive_seq: drives a JK flop bank to a requested target with settle, check and bounded retry.
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_target sampled on accept
//   q_fb                 Q outputs of the JK bank
//   j, k                 registered excitation, non-zero only for the single drive cycle
//   busy                 FSM not idle
//   done, err            one-cycle completion / retries-exhausted pulses
//   err_mask             bits differing at the final failed check, held until the next accept
// Build option JK_TOGGLE_EN (in jk_excite): toggle excitation instead of set/reset.
module jk_drive_seq
    import jk_drive_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

    state_t           state, state_n;
    logic [SW-1:0]    scnt;
    logic [RW-1:0]    rcnt;
    logic [WIDTH-1:0] tgt_q, tgt_n, ex_j, ex_k;
    logic             accept, miss, retry;

    assign req_ready = state == IDLE;
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    assign miss      = state == CHECK && q_fb != tgt_q;
    assign retry     = rcnt < RW'(MAX_RETRY);
    // On accept the excitation is computed from the incoming target so that J/K
    // are already registered during the drive cycle.
    assign tgt_n     = accept ? req_target : tgt_q;

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .tgt (tgt_n),
        .cur (q_fb),
        .j   (ex_j),
        .k   (ex_k)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? DRIVE : IDLE;
            DRIVE:   state_n = SETTLE;
            SETTLE:  state_n = scnt == '0 ? CHECK : SETTLE;
            CHECK:   state_n = miss && retry ? DRIVE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            scnt     <= '0;
            rcnt     <= '0;
            tgt_q    <= '0;
            j        <= '0;
            k        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_mask <= '0;
        end else begin
            state    <= state_n;
            tgt_q    <= tgt_n;
            j        <= state_n == DRIVE ? ex_j : '0;
            k        <= state_n == DRIVE ? ex_k : '0;
            scnt     <= state == DRIVE ? SW'(SETTLE_CYCLES - 1) : state == SETTLE ? scnt - SW'(1) : scnt;
            rcnt     <= accept ? '0 : miss && retry ? rcnt + RW'(1) : rcnt;
            done     <= state == CHECK && !miss;
            err      <= miss && !retry;
            err_mask <= accept ? '0 : miss && !retry ? q_fb ^ tgt_q : err_mask;
        end
    end
endmodule

// File: doc/jk_drive_seq.md
# jk_drive_seq

Excitation sequencer that drives a bank of WIDTH JK master-slave flip-flops to a requested target state. Each request arrives over a valid/ready handshake. The block then computes per-bit J/K excitation from the bank's current Q, applies it for one clock, waits a settle interval, and checks Q against the target. It retries on mismatch, up to a limit. It sits between control logic and the JK storage bank as that bank's writer.

## Interface
- WIDTH, 4: number of JK flops driven; range 1..32.
- SETTLE_CYCLES, 2: idle cycles between drive and check; minimum 1.
- MAX_RETRY, 1: re-drive attempts after the first mismatch; 0 means no retry.

- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Req_valid  in  1  request present.
- Req_ready  out  1  block can accept a request.
- Req_target  in  WIDTH  target Q value; sampled on accept.
- Q_fb  in  WIDTH  Q outputs of the JK bank.
- J  out  WIDTH  J excitation, registered.
- K  out  WIDTH  K excitation, registered.
- Busy  out  1  high whenever the FSM is not in IDLE.
- Done  out  1  one-cycle pulse: target reached.
- Err  out  1  one-cycle pulse: retries exhausted.
- Err_mask  out  WIDTH  bits that differed at the final check; held until the next accept.

## Operation
- Reset value of every output: Req_ready=1, J=0, K=0, Busy=0, Done=0, Err=0, Err_mask=0. The FSM resets to IDLE and the retry counter to 0.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE
  - Req_ready=1.
  - On Req_valid&&Req_ready: capture Req_target into tgt_q, clear the retry counter and Err_mask, go to DRIVE.
  - With Req_valid low, stay in IDLE.
- DRIVE (exactly 1 cycle)
  - J/K registers take the excitation computed from tgt_q and the Q_fb value sampled on entry.
  - Then go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles)
  - J=K=0, so the bank holds.
  - A down-counter loaded on entry; at zero, go to CHECK.
- CHECK (1 cycle), comparing Q_fb with tgt_q:
  - Equal: Done=1 on the next cycle; return to IDLE.
  - Not equal and retry counter < MAX_RETRY: increment the counter and go to DRIVE.
  - Not equal and counter == MAX_RETRY: Err=1 on the next cycle; Err_mask = Q_fb ^ tgt_q; return to IDLE.
- Req_ready is low in DRIVE, SETTLE and CHECK. Requests there are not accepted; Req_valid must be held.
- A target equal to the current Q still runs the full sequence. It reports Done after one pass.
- Rst low at any point: asynchronous return to the reset values. The request in flight is dropped with no Done/Err.

## Timing
- Accept edge is cycle 0.
- J/K valid during cycle 1.
- SETTLE occupies cycles 2..SETTLE_CYCLES+1.
- CHECK is cycle SETTLE_CYCLES+2.
- Done/Err is high in cycle SETTLE_CYCLES+3, together with Req_ready=1.
- Back-to-back: a request presented in the Done cycle is accepted in that cycle.
- Each retry adds SETTLE_CYCLES+2 cycles.
- Worst case, accept to Err: (MAX_RETRY+1)(SETTLE_CYCLES+2)+1 cycles.

## Configuration
- JK_TOGGLE_EN undefined (set/reset excitation): J=tgt_q, K=~tgt_q for every bit, independent of Q_fb.
- JK_TOGGLE_EN defined (toggle excitation): J=K=tgt_q^Q_fb.
  - Matching bits get 00 (hold); differing bits get 11 (toggle).
  - Q_fb is re-sampled at each DRIVE entry, including retries.
- Handshake, latency and Done/Err behaviour are identical in both builds.

## Structure
- Package jk_drive_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, CHECK);
  - the 2-bit JK code constants HOLD=00, RESET=01, SET=10, TOGGLE=11.
- Sub-module jk_excite: purely combinational, WIDTH-wide, mapping (tgt, cur) to (J, K). The JK_TOGGLE_EN selection lives here only.
- The top level holds the FSM, settle counter, retry counter, tgt_q, and the J/K/Err_mask registers.

## Test plan
All scenarios use WIDTH=4, SETTLE_CYCLES=2, MAX_RETRY=1, with a behavioural JK bank model.
- Reset: Rst low mid-SETTLE → J=K=0, Busy=0, Req_ready=1, Done=0 immediately; no Done/Err after release.
- Write, set/reset build: Q=4'b0000, target 4'b1010 → J=1010, K=0101 in cycle 1; Done in cycle 5; Q=1010.
- Write, toggle build: Q=4'b0110, target 4'b0011 → J=K=0101 in cycle 1; Done in cycle 5; Q=0011.
- Retry then error: bit 2 of the model stuck at 0, target 4'b0100 → two DRIVE passes; Err in cycle 9; Err_mask=0100; Done never asserts.
- Back-to-back: second request (4'b1111) held valid through the first → accepted in the first Done cycle; second Done 5 cycles later.
- No-op target: target equals Q=4'b1001 → one pass, Done in cycle 5; toggle build drives J=K=0000.
